// File: rtl/wb_unified_mem_if.sv
// Wishbone classic port bundle for wb_unified_mem.
// master: drives adr/wdat/sel/we/cyc/stb, receives rdat/ack/err.
// slave : the memory side of the same signals.
interface wb_unified_mem_if;
  logic [31:0] adr;
  logic [31:0] wdat;
  logic [3:0]  sel;
  logic        we;
  logic        cyc;
  logic        stb;
  logic [31:0] rdat;
  logic        ack;
  logic        err;

  modport master (output adr, wdat, sel, we, cyc, stb, input rdat, ack, err);
  modport slave  (input adr, wdat, sel, we, cyc, stb, output rdat, ack, err);
endinterface

// File: rtl/wb_unified_mem.sv
// Dual-port Wishbone unified memory: instruction port (iwb, read only) and
// data port (dwb) share one word array. Per-port wait states, byte-masked
// writes, out-of-range error responses, backdoor preload and a tohost
// mailbox with pass/fail/timeout status.
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   iwb               instruction port (slave); sel/we/wdat ignored
//   dwb               data port (slave)
//   init_*            backdoor full-word write, accepted every edge
//   tohost_o          last value written to the mailbox word
//   done_o/pass_o/fail_code_o/timeout_o  sticky test status
module wb_unified_mem #(
  parameter int unsigned ADDR_WIDTH  = 13,
  parameter int unsigned IWAIT       = 0,
  parameter int unsigned DWAIT       = 0,
  parameter int unsigned TOHOST_WORD = 1024,
  parameter int unsigned TIMEOUT     = 100000
) (
  input  logic                  clk,
  input  logic                  rst,
  wb_unified_mem_if.slave       iwb,
  wb_unified_mem_if.slave       dwb,
  input  logic                  init_we_i,
  input  logic [ADDR_WIDTH-1:0] init_adr_i,
  input  logic [31:0]           init_dat_i,
  output logic [31:0]           tohost_o,
  output logic                  done_o,
  output logic                  pass_o,
  output logic                  timeout_o,
  output logic [30:0]           fail_code_o
);
  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

  localparam int unsigned           DEPTH      = 2 ** ADDR_WIDTH;
  localparam logic [3:0]            IW         = 4'(IWAIT);
  localparam logic [3:0]            DW         = 4'(DWAIT);
  localparam logic [ADDR_WIDTH-1:0] TOHOST_IDX = ADDR_WIDTH'(TOHOST_WORD);
  localparam logic [31:0]           TMO        = 32'(TIMEOUT);

  logic [31:0] mem [0:DEPTH-1];

  // ---------------- instruction port ----------------
  state_t                i_state, i_next;
  logic [3:0]            i_cnt, i_cnt_next;
  logic [ADDR_WIDTH-1:0] i_idx_q, i_idx;
  logic                  i_oor_q, i_oor, i_commit;
  logic [31:0]           i_dat_q;

  // In IDLE the request fields come straight from the bus so a zero-wait
  // request can be served on the same edge it is latched.
  always_comb begin
    i_next     = i_state;
    i_cnt_next = i_cnt;
    i_idx      = i_idx_q;
    i_oor      = i_oor_q;
    i_commit   = 1'b0;
    unique case (i_state)
      S_IDLE: if (iwb.cyc && iwb.stb) begin
        i_idx = iwb.adr[ADDR_WIDTH+1:2];
        i_oor = |iwb.adr[31:ADDR_WIDTH+2];
        if (IW == 4'd0) begin
          i_next   = S_RESP;
          i_commit = 1'b1;
        end else begin
          i_next     = S_WAIT;
          i_cnt_next = IW;
        end
      end
      S_WAIT: begin
        if (!iwb.cyc) begin
          i_next     = S_IDLE;
          i_cnt_next = '0;
        end else if (i_cnt <= 4'd1) begin
          i_next     = S_RESP;
          i_commit   = 1'b1;
          i_cnt_next = '0;
        end else begin
          i_cnt_next = i_cnt - 4'd1;
        end
      end
      S_RESP:  i_next = S_IDLE;
      default: i_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      i_state <= S_IDLE;
      i_cnt   <= '0;
      i_idx_q <= '0;
      i_oor_q <= 1'b0;
      i_dat_q <= 32'h0000_0013;
    end else begin
      i_state <= i_next;
      i_cnt   <= i_cnt_next;
      i_idx_q <= i_idx;
      i_oor_q <= i_oor;
      if (i_commit && !i_oor) i_dat_q <= mem[i_idx];
    end
  end

  assign iwb.ack  = (i_state == S_RESP) && !i_oor_q;
  assign iwb.err  = (i_state == S_RESP) &&  i_oor_q;
  assign iwb.rdat = i_dat_q;

  // ---------------- data port ----------------
  state_t                d_state, d_next;
  logic [3:0]            d_cnt, d_cnt_next;
  logic [ADDR_WIDTH-1:0] d_idx_q, d_idx;
  logic                  d_oor_q, d_oor, d_we_q, d_we, d_commit, d_wr;
  logic [31:0]           d_wdat_q, d_wdat, d_dat_q, d_merged, d_mask;
  logic [3:0]            d_sel_q, d_sel;

  always_comb begin
    d_next     = d_state;
    d_cnt_next = d_cnt;
    d_idx      = d_idx_q;
    d_oor      = d_oor_q;
    d_wdat     = d_wdat_q;
    d_sel      = d_sel_q;
    d_we       = d_we_q;
    d_commit   = 1'b0;
    unique case (d_state)
      S_IDLE: if (dwb.cyc && dwb.stb) begin
        d_idx  = dwb.adr[ADDR_WIDTH+1:2];
        d_oor  = |dwb.adr[31:ADDR_WIDTH+2];
        d_wdat = dwb.wdat;
        d_sel  = dwb.sel;
        d_we   = dwb.we;
        if (DW == 4'd0) begin
          d_next   = S_RESP;
          d_commit = 1'b1;
        end else begin
          d_next     = S_WAIT;
          d_cnt_next = DW;
        end
      end
      S_WAIT: begin
        if (!dwb.cyc) begin
          d_next     = S_IDLE;
          d_cnt_next = '0;
        end else if (d_cnt <= 4'd1) begin
          d_next     = S_RESP;
          d_commit   = 1'b1;
          d_cnt_next = '0;
        end else begin
          d_cnt_next = d_cnt - 4'd1;
        end
      end
      S_RESP:  d_next = S_IDLE;
      default: d_next = S_IDLE;
    endcase
  end

  always_comb begin
    d_mask   = {{8{d_sel[3]}}, {8{d_sel[2]}}, {8{d_sel[1]}}, {8{d_sel[0]}}};
    d_merged = (mem[d_idx] & ~d_mask) | (d_wdat & d_mask);
  end

  assign d_wr = d_commit && !d_oor && d_we && !rst;

  always_ff @(posedge clk) begin
    if (rst) begin
      d_state  <= S_IDLE;
      d_cnt    <= '0;
      d_idx_q  <= '0;
      d_oor_q  <= 1'b0;
      d_wdat_q <= '0;
      d_sel_q  <= '0;
      d_we_q   <= 1'b0;
      d_dat_q  <= '0;
    end else begin
      d_state  <= d_next;
      d_cnt    <= d_cnt_next;
      d_idx_q  <= d_idx;
      d_oor_q  <= d_oor;
      d_wdat_q <= d_wdat;
      d_sel_q  <= d_sel;
      d_we_q   <= d_we;
      if (d_commit && !d_oor && !d_we) d_dat_q <= mem[d_idx];
    end
  end

  assign dwb.ack  = (d_state == S_RESP) && !d_oor_q;
  assign dwb.err  = (d_state == S_RESP) &&  d_oor_q;
  assign dwb.rdat = d_dat_q;

  // Backdoor write is issued last so it wins a same-word collision.
  always_ff @(posedge clk) begin
    if (d_wr)      mem[d_idx]      <= d_merged;
    if (init_we_i) mem[init_adr_i] <= init_dat_i;
  end

  // ---------------- mailbox and timeout ----------------
  logic [31:0] tmo_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      tmo_cnt     <= '0;
      tohost_o    <= '0;
      done_o      <= 1'b0;
      pass_o      <= 1'b0;
      timeout_o   <= 1'b0;
      fail_code_o <= '0;
    end else begin
      if (tmo_cnt != TMO) tmo_cnt <= tmo_cnt + 32'd1;
      if (TMO != 32'd0 && tmo_cnt == TMO - 32'd1 && !done_o) timeout_o <= 1'b1;
      if (d_wr && d_idx == TOHOST_IDX) begin
        tohost_o <= d_merged;
        if (d_merged != 32'd0 && !done_o) begin
          done_o      <= 1'b1;
          pass_o      <= (d_merged == 32'd1);
          fail_code_o <= d_merged[31:1];
        end
      end
    end
  end

  logic unused_bits;
  assign unused_bits = ^{iwb.wdat, iwb.sel, iwb.we, iwb.adr[1:0], dwb.adr[1:0]};
endmodule

// File: tb/tb_wb_unified_mem.sv
module tb_wb_unified_mem;
  localparam int AW  = 13;
  localparam int IW  = 0;
  localparam int DW  = 3;
  localparam int TMO = 50;
  localparam int TOHOST = 1024;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            init_we = 1'b0;
  logic [AW-1:0]   init_adr = '0;
  logic [31:0]     init_dat = '0;
  logic [31:0]     tohost;
  logic            done, pass, timeout;
  logic [30:0]     fail_code;

  wb_unified_mem_if iwb_bus ();
  wb_unified_mem_if dwb_bus ();

  wb_unified_mem #(
    .ADDR_WIDTH(AW), .IWAIT(IW), .DWAIT(DW), .TOHOST_WORD(TOHOST), .TIMEOUT(TMO)
  ) dut (
    .clk(clk), .rst(rst), .iwb(iwb_bus), .dwb(dwb_bus),
    .init_we_i(init_we), .init_adr_i(init_adr), .init_dat_i(init_dat),
    .tohost_o(tohost), .done_o(done), .pass_o(pass), .timeout_o(timeout),
    .fail_code_o(fail_code)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      if (n_fail <= 30) $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [31:0] mem_m [0:8191];
  int          edge_cnt = 0;
  int          rel = 0;
  bit          mvalid = 0;
  // one outstanding expectation per port: due edge, error flag, data
  int          i_due = -1, d_due = -1;
  bit          i_err_e, d_err_e, d_rd_e;
  logic [31:0] i_dat_e, d_dat_e, i_held, d_held;
  // one pending data write, committed on edge pw_c
  bit          pw_valid = 0;
  int          pw_c, pw_idx;
  logic [31:0] pw_dat;
  logic [3:0]  pw_sel;
  logic [31:0] tohost_m;
  bit          done_m, pass_m, tmo_m;
  logic [30:0] fail_m;

  function automatic void apply_pw();
    logic [31:0] w;
    w = mem_m[pw_idx];
    for (int k = 0; k < 4; k++)
      if (pw_sel[k[1:0]]) w[8*k +: 8] = pw_dat[8*k +: 8];
    mem_m[pw_idx] = w;
    if (pw_idx == TOHOST) begin
      tohost_m = w;
      if (w != 0 && !done_m) begin
        done_m = 1;
        pass_m = (w == 32'd1);
        fail_m = w[31:1];
      end
    end
    pw_valid = 0;
  endfunction

  // value seen by a read sampled on edge e (writes on the same edge are not yet visible)
  function automatic logic [31:0] model_read(input int idx, input int e);
    if (pw_valid && pw_c < e) apply_pw();
    return mem_m[idx];
  endfunction

  // compare process: advance the model every edge, check all outputs between edges
  initial begin : compare
    bit rst_e;
    bit eia, eie, eda, ede;
    forever begin
      @(posedge clk);
      rst_e = rst;
      edge_cnt++;
      if (rst_e) begin
        mvalid = 1; rel = 0;
        i_due = -1; d_due = -1; pw_valid = 0;
        i_held = 32'h13; d_held = 0;
        tohost_m = 0; done_m = 0; pass_m = 0; tmo_m = 0; fail_m = 0;
      end else begin
        rel++;
      end
      @(negedge clk);
      if (mvalid) begin
        if (!rst_e && rel == TMO && !done_m) tmo_m = 1;
        if (pw_valid && pw_c <= edge_cnt) apply_pw();
        eia = (i_due == edge_cnt) && !i_err_e;
        eie = (i_due == edge_cnt) &&  i_err_e;
        eda = (d_due == edge_cnt) && !d_err_e;
        ede = (d_due == edge_cnt) &&  d_err_e;
        if (eia) i_held = i_dat_e;
        if (eda && d_rd_e) d_held = d_dat_e;
        chk("iwb_ack", {31'd0, iwb_bus.ack}, {31'd0, eia});
        chk("iwb_err", {31'd0, iwb_bus.err}, {31'd0, eie});
        chk("dwb_ack", {31'd0, dwb_bus.ack}, {31'd0, eda});
        chk("dwb_err", {31'd0, dwb_bus.err}, {31'd0, ede});
        chk("iwb_dat", iwb_bus.rdat, i_held);
        chk("dwb_dat", dwb_bus.rdat, d_held);
        chk("tohost", tohost, tohost_m);
        chk("done", {31'd0, done}, {31'd0, done_m});
        chk("pass", {31'd0, pass}, {31'd0, pass_m});
        chk("fail_code", {1'b0, fail_code}, {1'b0, fail_m});
        chk("timeout", {31'd0, timeout}, {31'd0, tmo_m});
      end
    end
  end

  // ---------------- drivers ----------------
  task automatic wait_resp(input bit dport, output logic [31:0] rd,
                           output bit a, output bit e, output int lat, input int p);
    bit ok = 0;
    for (int n = 0; n < 40; n++) begin
      @(negedge clk);
      if (dport ? (dwb_bus.ack || dwb_bus.err) : (iwb_bus.ack || iwb_bus.err)) begin
        ok = 1;
        break;
      end
    end
    if (!ok) begin
      n_cmp++; n_fail++;
      $display("FAIL %s_resp: no response within 40 cycles, response required", dport ? "dwb" : "iwb");
    end
    rd  = dport ? dwb_bus.rdat : iwb_bus.rdat;
    a   = dport ? dwb_bus.ack : iwb_bus.ack;
    e   = dport ? dwb_bus.err : iwb_bus.err;
    lat = edge_cnt - p + 1;
    if (dport) begin dwb_bus.cyc = 0; dwb_bus.stb = 0; end
    else       begin iwb_bus.cyc = 0; iwb_bus.stb = 0; end
  endtask

  task automatic i_xfer(input logic [31:0] adr, output logic [31:0] rd,
                        output bit a, output bit e, output int lat);
    int p;
    @(negedge clk);
    iwb_bus.adr = adr; iwb_bus.cyc = 1; iwb_bus.stb = 1;
    p = edge_cnt + 1;
    i_err_e = |adr[31:AW+2];
    if (!i_err_e) i_dat_e = model_read(int'(adr[AW+1:2]), p + IW);
    i_due = p + IW;
    wait_resp(0, rd, a, e, lat, p);
  endtask

  task automatic d_xfer(input logic [31:0] adr, input logic [31:0] dat, input logic [3:0] sel,
                        input bit we, output logic [31:0] rd, output bit a, output bit e,
                        output int lat);
    int p;
    @(negedge clk);
    dwb_bus.adr = adr; dwb_bus.wdat = dat; dwb_bus.sel = sel; dwb_bus.we = we;
    dwb_bus.cyc = 1; dwb_bus.stb = 1;
    p = edge_cnt + 1;
    d_err_e = |adr[31:AW+2];
    d_rd_e  = !we;
    if (!d_err_e && !we) d_dat_e = model_read(int'(adr[AW+1:2]), p + DW);
    if (!d_err_e && we) begin
      pw_valid = 1; pw_c = p + DW; pw_idx = int'(adr[AW+1:2]); pw_dat = dat; pw_sel = sel;
    end
    d_due = p + DW;
    wait_resp(1, rd, a, e, lat, p);
  endtask

  task automatic preload(input int idx, input logic [31:0] v);
    @(negedge clk);
    init_we = 1; init_adr = AW'(idx); init_dat = v;
    mem_m[idx] = v;
  endtask

  // ---------------- directed sequence ----------------
  initial begin : main
    logic [31:0] rd, rdi;
    bit a, e, ai, ei;
    int lat, lati;
    iwb_bus.adr = 0; iwb_bus.wdat = 0; iwb_bus.sel = 0; iwb_bus.we = 0;
    iwb_bus.cyc = 0; iwb_bus.stb = 0;
    dwb_bus.adr = 0; dwb_bus.wdat = 0; dwb_bus.sel = 0; dwb_bus.we = 0;
    dwb_bus.cyc = 0; dwb_bus.stb = 0;

    // backdoor preload while held in reset
    for (int i = 0; i < 128; i++) preload(i, 32'h0000_0013);
    preload(0, 32'h0050_0093);
    preload(64, 32'h0000_0000);
    preload(TOHOST, 32'h0000_0000);
    @(negedge clk);
    init_we = 0;
    chk("rst_iwb_dat", iwb_bus.rdat, 32'h0000_0013);
    chk("rst_dwb_dat", dwb_bus.rdat, 32'h0);
    chk("rst_done", {31'd0, done}, 32'h0);
    rst = 0;

    // timeout rises exactly TMO edges after release
    while (rel < TMO - 1) @(negedge clk);
    chk("timeout_before", {31'd0, timeout}, 32'h0);
    @(negedge clk);
    chk("timeout_at", {31'd0, timeout}, 32'h1);

    // zero-wait fetch
    i_xfer(32'h0, rd, a, e, lat);
    chk("fetch0_dat", rd, 32'h0050_0093);
    chk("fetch0_lat", lat, 1);

    // masked write with 3 wait states, then read back
    d_xfer(32'h100, 32'hDEAD_BEEF, 4'b0101, 1, rd, a, e, lat);
    chk("wr100_lat", lat, 4);
    chk("wr100_ack", {31'd0, a}, 32'h1);
    d_xfer(32'h100, 32'h0, 4'hF, 0, rd, a, e, lat);
    chk("rd100_dat", rd, 32'h00AD_00EF);

    // same-edge write and fetch of word 0x40
    fork
      d_xfer(32'h40, 32'h1234, 4'hF, 1, rd, a, e, lat);
      begin
        repeat (3) @(negedge clk);
        i_xfer(32'h40, rdi, ai, ei, lati);
      end
    join
    chk("collide_old", rdi, 32'h0000_0013);
    i_xfer(32'h40, rd, a, e, lat);
    chk("collide_new", rd, 32'h0000_1234);

    // out-of-range accesses; 0x10100 would alias word 0x100 without the check
    i_xfer(32'h0001_0000, rd, a, e, lat);
    chk("oor_iwb_err", {31'd0, e}, 32'h1);
    chk("oor_iwb_hold", rd, 32'h0000_1234);
    d_xfer(32'h0001_0100, 32'hFFFF_FFFF, 4'hF, 1, rd, a, e, lat);
    chk("oor_dwb_err", {31'd0, e}, 32'h1);
    chk("oor_dwb_noack", {31'd0, a}, 32'h0);
    chk("oor_dwb_hold", rd, 32'h00AD_00EF);

    // abort during WAIT: no response and no write
    @(negedge clk);
    dwb_bus.adr = 32'h100; dwb_bus.wdat = 32'h1111_1111; dwb_bus.sel = 4'hF; dwb_bus.we = 1;
    dwb_bus.cyc = 1; dwb_bus.stb = 1;
    @(negedge clk);
    @(negedge clk);
    dwb_bus.cyc = 0; dwb_bus.stb = 0;
    repeat (6) @(negedge clk);
    d_xfer(32'h100, 32'h0, 4'hF, 0, rd, a, e, lat);
    chk("abort_nowrite", rd, 32'h00AD_00EF);

    // mailbox pass
    d_xfer(32'h1000, 32'h1, 4'hF, 1, rd, a, e, lat);
    chk("mb1_done", {31'd0, done}, 32'h1);
    chk("mb1_pass", {31'd0, pass}, 32'h1);

    // reset pulse clears all status
    @(negedge clk);
    rst = 1;
    @(negedge clk);
    chk("rst2_done", {31'd0, done}, 32'h0);
    chk("rst2_pass", {31'd0, pass}, 32'h0);
    chk("rst2_timeout", {31'd0, timeout}, 32'h0);
    chk("rst2_tohost", tohost, 32'h0);
    rst = 0;

    // mailbox fail code, then sticky status
    d_xfer(32'h1000, 32'h7, 4'hF, 1, rd, a, e, lat);
    chk("mb7_done", {31'd0, done}, 32'h1);
    chk("mb7_pass", {31'd0, pass}, 32'h0);
    chk("mb7_code", {1'b0, fail_code}, 32'h3);
    d_xfer(32'h1000, 32'h1, 4'hF, 1, rd, a, e, lat);
    chk("mb_again_tohost", tohost, 32'h1);
    chk("mb_again_pass", {31'd0, pass}, 32'h0);
    chk("mb_again_code", {1'b0, fail_code}, 32'h3);

    repeat (4) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation still running at %0t, completion required", $time);
    $fatal(1, "watchdog expired");
  end
endmodule
